// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
// Ports: imem_req/imem_addr out of master; imem_ready/imem_rvalid/imem_rdata into master.
interface fetch_stage_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ready,
      input  imem_rvalid,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ready,
      output imem_rvalid,
      output imem_rdata
   );
endinterface

// File: rtl/fetch_stage.sv
// RV32I fetch stage with IF/ID register: owns the PC, one outstanding imem request,
// a one-entry hold buffer for decode stalls, and redirects with stale-response dropping.
// Ports: clk, reset (sync, active low), StallD/FlushD from hazard unit,
//   PCSrcE/PCTargetE from execute, imem (master bus), InstrD/PC_nowD/PC_plus4D/validD to decode.
module fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 StallD,
   input  logic                 FlushD,
   input  logic                 PCSrcE,
   input  logic [31:0]          PCTargetE,
   fetch_stage_if.master        imem,
   output logic [31:0]          InstrD,
   output logic [31:0]          PC_nowD,
   output logic [31:0]          PC_plus4D,
   output logic                 validD
);

   typedef enum logic [1:0] {
      REQ  = 2'd0,
      WAIT = 2'd1,
      HOLD = 2'd2,
      DROP = 2'd3
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic [31:0] pc;
   logic [31:0] pc_nxt;
   logic [31:0] pc_plus4;
   logic [31:0] hold_instr;
   logic [31:0] hold_pc;
   logic        hold_load;
   logic        resp;

   assign pc_plus4       = pc + 32'd4;
   assign imem.imem_req  = (state == REQ);
   assign imem.imem_addr = pc;

   // only a response in WAIT belongs to the live request
   assign resp = (state == WAIT) & imem.imem_rvalid;

   always_comb begin
      state_nxt = state;
      pc_nxt    = pc;
      hold_load = 1'b0;
      case (state)
         REQ: begin
            if (imem.imem_ready) state_nxt = WAIT;
         end
         WAIT: begin
            if (imem.imem_rvalid) begin
               pc_nxt = pc_plus4;
               if (StallD) begin
                  state_nxt = HOLD;
                  hold_load = 1'b1;
               end else begin
                  state_nxt = REQ;
               end
            end
         end
         HOLD: begin
            if (!StallD) state_nxt = REQ;
         end
         DROP: begin
            if (imem.imem_rvalid) state_nxt = REQ;
         end
         default: state_nxt = REQ;
      endcase

      // a redirect wins; an accepted or unanswered request becomes stale
      if (PCSrcE) begin
         pc_nxt    = PCTargetE & ~32'h3;
         hold_load = 1'b0;
         case (state)
            REQ:     state_nxt = imem.imem_ready ? DROP : REQ;
            WAIT:    state_nxt = imem.imem_rvalid ? REQ : DROP;
            HOLD:    state_nxt = REQ;
            DROP:    state_nxt = imem.imem_rvalid ? REQ : DROP;
            default: state_nxt = REQ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= REQ;
         pc    <= RESET_PC;
      end else begin
         state <= state_nxt;
         pc    <= pc_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset || PCSrcE) begin
         hold_instr <= 32'd0;
         hold_pc    <= 32'd0;
      end else if (hold_load) begin
         hold_instr <= imem.imem_rdata;
         hold_pc    <= pc;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         InstrD    <= NOP_INSTR;
         PC_nowD   <= 32'd0;
         PC_plus4D <= 32'd4;
         validD    <= 1'b0;
      end else if (PCSrcE || FlushD) begin
         InstrD <= NOP_INSTR;
         validD <= 1'b0;
      end else if (!StallD) begin
         if (resp) begin
            InstrD    <= imem.imem_rdata;
            PC_nowD   <= pc;
            PC_plus4D <= pc_plus4;
            validD    <= 1'b1;
         end else if (state == HOLD) begin
            InstrD    <= hold_instr;
            PC_nowD   <= hold_pc;
            PC_plus4D <= hold_pc + 32'd4;
            validD    <= 1'b1;
         end else begin
            InstrD <= NOP_INSTR;
            validD <= 1'b0;
         end
      end
   end

endmodule
